// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: field widths, the decoded control bundle, hazard helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

    // Width of the decoded ALU operation field.
    localparam int ALUOP_W = 3;
    // Width of an architectural register number.
    localparam int REG_W   = 5;

    typedef logic [REG_W-1:0] reg_num_t;

    // Decoded control carried through ID/EX; an all-zero value is a bubble.
    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               reg_dst;
        logic               jmp;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    // True when a producer register is a real destination and a consumer reads it.
    // Register 0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_dep(input reg_num_t producer, input reg_num_t consumer);
        return (producer != '0) && (producer == consumer);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction reading the register a load in EX is writing.
// Latency: purely combinational, same cycle.
// Backpressure: o_stall is forced low while the pipeline is held or in reset.
//
// Ports:
//   i_ex_mem_read  load currently in ID/EX
//   i_ex_rt        destination register of that load
//   i_id_rs/rt     source registers of the instruction in IF/ID
//   i_hold/reset   suppress the stall request
//   o_stall        hold PC and IF/ID, insert a bubble into ID/EX
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_hold,
    input  logic             i_reset,
    output logic             o_stall
);

    logic w_dep;

    assign w_dep   = i_ex_mem_read &&
                     (reg_dep(i_ex_rt, i_id_rs) || reg_dep(i_ex_rt, i_id_rt));

    // A held pipeline cannot insert a bubble anyway; reset clears ID/EX itself.
    assign o_stall = w_dep && !i_hold && !i_reset;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and a saturating bubble counter.
// Latency: 1 cycle from ID_* inputs to ID_EX_* outputs; Stall is combinational.
// Backpressure: Hold freezes every register; Flush/Stall load a bubble instead of the ID instruction.
//
// Ports:
//   clk, reset                     single clock, synchronous active-high reset
//   IF_ID_Register*, ID_*          decoded instruction entering ID/EX
//   Hold, Flush                    freeze / squash requests
//   ID_EX_*                        registered ID/EX contents
//   Stall                          load-use hazard, holds PC and IF/ID
//   BubbleCount                    saturating count of load-use bubbles
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REG_W-1:0]   IF_ID_RegisterRS,
    input  logic [REG_W-1:0]   IF_ID_RegisterRT,
    input  logic [REG_W-1:0]   IF_ID_RegisterRD,
    input  logic [DATA_W-1:0]  ID_ReadData1,
    input  logic [DATA_W-1:0]  ID_ReadData2,
    input  logic [DATA_W-1:0]  ID_SignExtImm,
    input  logic [DATA_W-1:0]  ID_PCPlus4,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemtoReg,
    input  logic               ID_ALUSrc,
    input  logic               ID_RegDst,
    input  logic               ID_JMP,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic               Hold,
    input  logic               Flush,
    output logic [REG_W-1:0]   ID_EX_RegisterRS,
    output logic [REG_W-1:0]   ID_EX_RegisterRT,
    output logic [REG_W-1:0]   ID_EX_RegisterRD,
    output logic [DATA_W-1:0]  ID_EX_ReadData1,
    output logic [DATA_W-1:0]  ID_EX_ReadData2,
    output logic [DATA_W-1:0]  ID_EX_SignExtImm,
    output logic [DATA_W-1:0]  ID_EX_PCPlus4,
    output logic               ID_EX_RegWrite,
    output logic               ID_EX_MemRead,
    output logic               ID_EX_MemWrite,
    output logic               ID_EX_MemtoReg,
    output logic               ID_EX_ALUSrc,
    output logic               ID_EX_RegDst,
    output logic               ID_EX_JMP,
    output logic [ALUOP_W-1:0] ID_EX_ALUOp,
    output logic               Stall,
    output logic [CNT_W-1:0]   BubbleCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ctrl_t              r_ctrl;
    logic [REG_W-1:0]   r_rs;
    logic [REG_W-1:0]   r_rt;
    logic [REG_W-1:0]   r_rd;
    logic [DATA_W-1:0]  r_rd1;
    logic [DATA_W-1:0]  r_rd2;
    logic [DATA_W-1:0]  r_imm;
    logic [DATA_W-1:0]  r_pc4;
    logic [CNT_W-1:0]   r_bubble_cnt;

    ctrl_t              w_ctrl_in;
    logic               w_stall;
    logic               w_bubble;
    logic               w_count;

    assign w_ctrl_in = {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg,
                        ID_ALUSrc, ID_RegDst, ID_JMP, ID_ALUOp};

    hazard_detect u_hazard_detect (
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rt       (r_rt),
        .i_id_rs       (IF_ID_RegisterRS),
        .i_id_rt       (IF_ID_RegisterRT),
        .i_hold        (Hold),
        .i_reset       (reset),
        .o_stall       (w_stall)
    );

    // w_stall is already low under Hold/reset, so these only matter on a live cycle.
    // A squashed (flushed) slot is not a load-use bubble even if a stall was also raised.
    assign w_bubble = Flush | w_stall;
    assign w_count  = w_stall & ~Flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl       <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_pc4        <= '0;
            r_bubble_cnt <= '0;
        end else if (!Hold) begin
            if (w_bubble) begin
                // Bubble zeroes register numbers too so no forwarding path can match it.
                r_ctrl <= '0;
                r_rs   <= '0;
                r_rt   <= '0;
                r_rd   <= '0;
                r_rd1  <= '0;
                r_rd2  <= '0;
                r_imm  <= '0;
                r_pc4  <= '0;
            end else begin
                r_ctrl <= w_ctrl_in;
                r_rs   <= IF_ID_RegisterRS;
                r_rt   <= IF_ID_RegisterRT;
                r_rd   <= IF_ID_RegisterRD;
                r_rd1  <= ID_ReadData1;
                r_rd2  <= ID_ReadData2;
                r_imm  <= ID_SignExtImm;
                r_pc4  <= ID_PCPlus4;
            end
            if (w_count && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
        end
    end

    assign ID_EX_RegisterRS = r_rs;
    assign ID_EX_RegisterRT = r_rt;
    assign ID_EX_RegisterRD = r_rd;
    assign ID_EX_ReadData1  = r_rd1;
    assign ID_EX_ReadData2  = r_rd2;
    assign ID_EX_SignExtImm = r_imm;
    assign ID_EX_PCPlus4    = r_pc4;
    assign ID_EX_RegWrite   = r_ctrl.reg_write;
    assign ID_EX_MemRead    = r_ctrl.mem_read;
    assign ID_EX_MemWrite   = r_ctrl.mem_write;
    assign ID_EX_MemtoReg   = r_ctrl.mem_to_reg;
    assign ID_EX_ALUSrc     = r_ctrl.alu_src;
    assign ID_EX_RegDst     = r_ctrl.reg_dst;
    assign ID_EX_JMP        = r_ctrl.jmp;
    assign ID_EX_ALUOp      = r_ctrl.alu_op;
    assign Stall            = w_stall;
    assign BubbleCount      = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes expected Stall and next-cycle contents,
// an independent monitor pops and compares. Counter width 4 exercises saturation at 15.
module tb_id_ex_stage;

    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rd1, rd2, imm, pc4;
        logic        regwrite, memread, memwrite, memtoreg, alusrc, regdst, jmp;
        logic [2:0]  aluop;
    } fields_t;

    typedef struct packed {
        logic    rst, hold, flush;
        fields_t f;
    } in_t;

    typedef struct packed {
        fields_t    f;
        logic [3:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  IF_ID_RegisterRS = '0, IF_ID_RegisterRT = '0, IF_ID_RegisterRD = '0;
    logic [31:0] ID_ReadData1 = '0, ID_ReadData2 = '0, ID_SignExtImm = '0, ID_PCPlus4 = '0;
    logic        ID_RegWrite = 0, ID_MemRead = 0, ID_MemWrite = 0, ID_MemtoReg = 0;
    logic        ID_ALUSrc = 0, ID_RegDst = 0, ID_JMP = 0;
    logic [2:0]  ID_ALUOp = '0;
    logic        Hold = 0, Flush = 0;
    logic [4:0]  ID_EX_RegisterRS, ID_EX_RegisterRT, ID_EX_RegisterRD;
    logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm, ID_EX_PCPlus4;
    logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg;
    logic        ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_JMP;
    logic [2:0]  ID_EX_ALUOp;
    logic        Stall;
    logic [3:0]  BubbleCount;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_RegisterRS(IF_ID_RegisterRS), .IF_ID_RegisterRT(IF_ID_RegisterRT),
        .IF_ID_RegisterRD(IF_ID_RegisterRD),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
        .ID_SignExtImm(ID_SignExtImm), .ID_PCPlus4(ID_PCPlus4),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
        .ID_JMP(ID_JMP), .ID_ALUOp(ID_ALUOp), .Hold(Hold), .Flush(Flush),
        .ID_EX_RegisterRS(ID_EX_RegisterRS), .ID_EX_RegisterRT(ID_EX_RegisterRT),
        .ID_EX_RegisterRD(ID_EX_RegisterRD),
        .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
        .ID_EX_SignExtImm(ID_EX_SignExtImm), .ID_EX_PCPlus4(ID_EX_PCPlus4),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
        .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_RegDst(ID_EX_RegDst), .ID_EX_JMP(ID_EX_JMP),
        .ID_EX_ALUOp(ID_EX_ALUOp), .Stall(Stall), .BubbleCount(BubbleCount)
    );

    int total = 0;
    int bad   = 0;

    logic stall_q[$];
    exp_t state_q[$];

    // Reference model: what the ID/EX slot holds and how many load-use bubbles so far.
    fields_t m_f   = '0;
    int      m_cnt = 0;

    function automatic fields_t mk(input logic [4:0] rs, rt, rd, input logic lw, add);
        fields_t f;
        f.rs = rs; f.rt = rt; f.rd = rd;
        f.rd1 = $urandom; f.rd2 = $urandom; f.imm = $urandom; f.pc4 = $urandom;
        f.regwrite = lw | add; f.memread = lw; f.memwrite = 1'b0; f.memtoreg = lw;
        f.alusrc = lw; f.regdst = add; f.jmp = 1'b0; f.aluop = add ? 3'd2 : 3'd0;
        return f;
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic fields_t rand_fields();
        fields_t f;
        f = mk(pick_reg(), pick_reg(), 5'($urandom), 1'b0, 1'b0);
        f.regwrite = 1'($urandom); f.memread = ($urandom_range(0, 1) == 0);
        f.memwrite = 1'($urandom); f.memtoreg = 1'($urandom); f.alusrc = 1'($urandom);
        f.regdst = 1'($urandom); f.jmp = 1'($urandom); f.aluop = 3'($urandom);
        return f;
    endfunction

    function automatic in_t op(input logic rst, hold, flush, input fields_t f);
        in_t s;
        s.rst = rst; s.hold = hold; s.flush = flush; s.f = f;
        return s;
    endfunction

    task automatic drive(input in_t s);
        logic exp_stall;
        exp_t e;
        @(negedge clk);
        reset = s.rst; Hold = s.hold; Flush = s.flush;
        IF_ID_RegisterRS = s.f.rs; IF_ID_RegisterRT = s.f.rt; IF_ID_RegisterRD = s.f.rd;
        ID_ReadData1 = s.f.rd1; ID_ReadData2 = s.f.rd2;
        ID_SignExtImm = s.f.imm; ID_PCPlus4 = s.f.pc4;
        ID_RegWrite = s.f.regwrite; ID_MemRead = s.f.memread; ID_MemWrite = s.f.memwrite;
        ID_MemtoReg = s.f.memtoreg; ID_ALUSrc = s.f.alusrc; ID_RegDst = s.f.regdst;
        ID_JMP = s.f.jmp; ID_ALUOp = s.f.aluop;
        // A load in EX blocks any ID reader of its nonzero destination.
        exp_stall = !s.rst && !s.hold && m_f.memread && (m_f.rt != 0) &&
                    (m_f.rt == s.f.rs || m_f.rt == s.f.rt);
        stall_q.push_back(exp_stall);
        if (s.rst) begin
            m_f = '0; m_cnt = 0;
        end else if (s.hold) begin
            // nothing moves
        end else if (s.flush || exp_stall) begin
            m_f = '0;
            if (exp_stall && !s.flush && m_cnt < 15) m_cnt++;
        end else begin
            m_f = s.f;
        end
        e.f = m_f; e.cnt = 4'(m_cnt);
        state_q.push_back(e);
    endtask

    // Monitor: Stall just after inputs settle, registered contents just after the edge.
    initial begin
        logic    es;
        exp_t    e;
        fields_t a;
        forever begin
            @(negedge clk);
            #2;
            if (stall_q.size() != 0) begin
                es = stall_q.pop_front();
                total++;
                if (Stall !== es) begin
                    bad++;
                    $display("FAIL stall t=%0t got=%b want=%b", $time, Stall, es);
                end
            end
            @(posedge clk);
            #1;
            if (state_q.size() != 0) begin
                e = state_q.pop_front();
                a = {ID_EX_RegisterRS, ID_EX_RegisterRT, ID_EX_RegisterRD,
                     ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm, ID_EX_PCPlus4,
                     ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
                     ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_JMP, ID_EX_ALUOp};
                total++;
                if (a !== e.f) begin
                    bad++;
                    $display("FAIL id_ex_fields t=%0t got=%h want=%h", $time, a, e.f);
                end
                total++;
                if (BubbleCount !== e.cnt) begin
                    bad++;
                    $display("FAIL bubble_count t=%0t got=%0d want=%0d", $time, BubbleCount, e.cnt);
                end
            end
        end
    end

    initial begin
        fields_t nop;
        nop = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0);

        // Reset state.
        drive(op(1, 0, 0, nop));
        drive(op(1, 1, 1, nop));

        // lw $t0 then a reader of $t0: one bubble, counter to 1, then it proceeds.
        drive(op(0, 0, 0, mk(5'd1, 5'd8, 5'd0, 1, 0)));
        drive(op(0, 0, 0, mk(5'd8, 5'd3, 5'd4, 0, 1)));
        drive(op(0, 0, 0, mk(5'd8, 5'd3, 5'd4, 0, 1)));

        // lw to $zero followed by a $zero reader: no stall.
        drive(op(0, 0, 0, mk(5'd2, 5'd0, 5'd0, 1, 0)));
        drive(op(0, 0, 0, mk(5'd0, 5'd0, 5'd5, 0, 1)));

        // Flush of a valid add, and flush coinciding with a load-use hazard.
        drive(op(0, 0, 1, mk(5'd6, 5'd7, 5'd9, 0, 1)));
        drive(op(0, 0, 0, mk(5'd1, 5'd9, 5'd0, 1, 0)));
        drive(op(0, 0, 1, mk(5'd9, 5'd9, 5'd4, 0, 1)));

        // Hold over a pending load-use for 3 cycles, then release.
        drive(op(0, 0, 0, mk(5'd1, 5'd8, 5'd0, 1, 0)));
        for (int i = 0; i < 3; i++) drive(op(0, 1, 0, mk(5'd8, 5'd2, 5'd4, 0, 1)));
        drive(op(0, 0, 0, mk(5'd8, 5'd2, 5'd4, 0, 1)));

        // Reset while a stall is pending and Hold is up.
        drive(op(0, 0, 0, mk(5'd1, 5'd8, 5'd0, 1, 0)));
        drive(op(1, 1, 0, mk(5'd8, 5'd8, 5'd4, 0, 1)));
        drive(op(0, 0, 0, mk(5'd8, 5'd8, 5'd4, 0, 1)));

        // Back-to-back loads that depend on each other: 20 bubbles, counter stops at 15.
        for (int i = 0; i < 40; i++) drive(op(0, 0, 0, mk(5'd8, 5'd8, 5'd0, 1, 0)));

        // Randomized traffic with occasional hold, flush and reset.
        for (int i = 0; i < 400; i++) begin
            drive(op($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 9) == 0, rand_fields()));
        end

        for (int i = 0; i < 4 && (stall_q.size() != 0 || state_q.size() != 0); i++)
            @(negedge clk);
        #3;
        if (stall_q.size() != 0 || state_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending_stall=%0d pending_state=%0d want=0",
                     stall_q.size(), state_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
